red_pitaya_pfd_sched: RTL
=========================

RED_PITAYA_PFD_SCHED -- requirements
Module: red_pitaya_pfd_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of signal-pair channels sharing one PFD block (2..8).
REQ-002 SHALL have parameter DWELLW, default 24, meaning the width of the dwell counter.
REQ-003 SHALL have port clk_i, input, 1, the single system clock.
REQ-004 SHALL have port rstn_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable_i, input, 1: scan enable.
REQ-006 SHALL have port ch_mask_i, input, NCH: channels included in the scan.
REQ-007 SHALL have port settle_i, input, 8: discard cycles after switching.
REQ-008 SHALL have port dwell_i, input, DWELLW: measurement cycles per slot.
REQ-009 SHALL have ports s1_i and s2_i, input, NCH each: per-channel signal pairs.
REQ-010 SHALL have ports pfd_s1_o and pfd_s2_o, output, 1 each: gated, muxed signals to the PFD.
REQ-011 SHALL have port pfd_rstn_o, output, 1: synchronous reset to the PFD block.
REQ-012 SHALL have port pfd_integral_i, input, 14: signed PFD integral.
REQ-013 SHALL have port sel_o, output, 3: current channel index.
REQ-014 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.
REQ-015 SHALL have port result_o, output, 14*NCH: last signed result per channel, with channel k at bits [14k+13:14k].
REQ-016 SHALL have port result_valid_o, output, 1: one-cycle strobe.
REQ-017 SHALL have port result_ch_o, output, 3: channel of the strobed result.

Function
REQ-018 SHALL implement the FSM states IDLE, CLEAR, SETTLE, DWELL and CAPTURE.
REQ-019 SHALL move IDLE->CLEAR when enable_i=1 and |ch_mask_i=1, loading sel_o with the lowest set mask bit.
REQ-020 SHALL hold CLEAR for exactly 2 cycles, then go to SETTLE if settle_i!=0, else to DWELL.
REQ-021 SHALL hold SETTLE for settle_i cycles, with settle_i sampled on CLEAR exit.
REQ-022 SHALL hold DWELL for max(dwell_i,1) cycles, with dwell_i sampled on DWELL entry.
REQ-023 SHALL hold CAPTURE for 1 cycle, then go to CLEAR for the next channel.
REQ-024 SHALL select the next channel as the lowest set ch_mask_i bit strictly above sel_o, wrapping to bit 0; mask is sampled in CAPTURE; a single-bit mask repeats the same channel.
REQ-025 SHALL drive pfd_rstn_o=0 in IDLE and CLEAR, and 1 otherwise.
REQ-026 SHALL drive pfd_s1_o/pfd_s2_o from s1_i[sel_o]/s2_i[sel_o] through a 2-flop synchronizer in SETTLE and DWELL, and force them to 0 otherwise.
REQ-027 SHALL register pfd_integral_i into base on the first DWELL cycle.
REQ-028 SHALL, in CAPTURE, compute diff = pfd_integral_i - base in 15-bit signed arithmetic.
REQ-029 SHALL saturate diff to [-8192, 8191] and write it to result_o slice sel_o at the CAPTURE clock edge.
REQ-030 SHALL assert result_valid_o with result_ch_o=captured channel for exactly the one cycle following CAPTURE.
REQ-031 SHALL go to IDLE on the next edge from any state when enable_i=0 or the sampled mask is 0, with no strobe and result_o unchanged.
REQ-032 SHALL give enable_i deassertion priority when it coincides with CAPTURE: no write and no strobe.
REQ-033 SHALL let ch_mask_i changes mid-slot take effect only at the next channel selection.
REQ-034 SHALL keep result_o slices of unmasked channels at their last value.

Reset
REQ-035 SHALL, while rstn_i=0 (asynchronously), force: state=IDLE, sel_o=0, busy_o=0, pfd_rstn_o=0, pfd_s1_o=pfd_s2_o=0, result_o=0, result_valid_o=0, result_ch_o=0, base=0, counters=0, synchronizers=0.
REQ-036 SHALL resume at IDLE on the first clock edge after rstn_i release, with no strobe.

Verification
REQ-037 SHALL cover: mask=0001, settle=0, dwell=1000, s1_i[0] rising every 10 cycles, s2 idle, PFD model attached -> result_o[13:0]=+100±1, strobe 1004 cycles after enable_i rises, result_ch_o=0.
REQ-038 SHALL cover: mask=0101, dwell=8, settle=3 -> sel_o sequence 0,2,0,2, each slot 2+3+8+1 cycles, pfd_rstn_o low exactly in the 2 CLEAR cycles.
REQ-039 SHALL cover: forced pfd_integral_i base=-8000 and end=8000 -> result=8191; base=8000 and end=-8000 -> result=-8192.
REQ-040 SHALL cover: enable_i dropped in DWELL cycle 5 -> IDLE next cycle, pfd_rstn_o=0, no result_valid_o, result_o unchanged.
REQ-041 SHALL cover: rstn_i pulsed low between clock edges mid-DWELL -> all outputs at reset values before the next edge; rescan restarts at the lowest mask bit.
REQ-042 SHALL cover: dwell_i=0 -> DWELL lasts 1 cycle; mask changed 0011->1000 during DWELL of channel 0 -> next sel_o=3.

Source files
------------

// File: rtl/red_pitaya_pfd_sched.sv
// red_pitaya_pfd_sched
//   Time-multiplexes one phase-frequency detector (PFD) across NCH signal
//   pairs. Each channel slot runs CLEAR (PFD held in reset) -> optional SETTLE
//   (signals flow, result discarded) -> DWELL (measurement window) -> CAPTURE
//   (integral delta stored, saturated to 14 bits). Channels rotate through
//   the set bits of ch_mask_i.
//
// Ports
//   clk_i, rstn_i        system clock, asynchronous active-low reset
//   enable_i             scan enable; deassertion returns to IDLE next edge
//   ch_mask_i[NCH]       channels taking part in the scan
//   settle_i[8]          discard cycles after each channel switch
//   dwell_i[DWELLW]      measurement cycles per slot (0 treated as 1)
//   s1_i, s2_i[NCH]      per-channel signal pairs
//   pfd_s1_o, pfd_s2_o   synchronized, gated signals of the selected channel
//   pfd_rstn_o           synchronous reset to the PFD (low in IDLE and CLEAR)
//   pfd_integral_i[14]   signed PFD integral
//   sel_o[3]             currently selected channel
//   busy_o               high whenever the scheduler is not idle
//   result_o[14*NCH]     last signed result per channel (channel k at 14k+:14)
//   result_valid_o       one-cycle strobe after each capture
//   result_ch_o[3]       channel of the strobed result

module red_pitaya_pfd_sched #(
  parameter int NCH    = 4,
  parameter int DWELLW = 24
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enable_i,
  input  logic [NCH-1:0]    ch_mask_i,
  input  logic [7:0]        settle_i,
  input  logic [DWELLW-1:0] dwell_i,
  input  logic [NCH-1:0]    s1_i,
  input  logic [NCH-1:0]    s2_i,
  output logic              pfd_s1_o,
  output logic              pfd_s2_o,
  output logic              pfd_rstn_o,
  input  logic [13:0]       pfd_integral_i,
  output logic [2:0]        sel_o,
  output logic              busy_o,
  output logic [14*NCH-1:0] result_o,
  output logic              result_valid_o,
  output logic [2:0]        result_ch_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_DWELL,
    S_CAPTURE
  } state_e;

  // Lowest set bit of the mask (0 when the mask is empty).
  function automatic logic [2:0] first_ch(input logic [NCH-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) c = 3'(i);
    end
    return c;
  endfunction

  // Lowest set bit strictly above cur, wrapping to the lowest set bit.
  // A single-bit mask naturally yields cur again.
  function automatic logic [2:0] next_ch(input logic [NCH-1:0] m, input logic [2:0] cur);
    logic [2:0] c;
    logic       found;
    c     = first_ch(m);
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && m[i] && (3'(i) > cur)) begin
        c     = 3'(i);
        found = 1'b1;
      end
    end
    return c;
  endfunction

  state_e            state_q, state_d;
  logic [DWELLW-1:0] cnt_q, cnt_d;      // cycles remaining in the current state, minus one
  logic [2:0]        sel_q, sel_d;
  logic              wr_en;             // CAPTURE completes with a result write
  logic              first_q;           // first DWELL cycle of the slot
  logic [13:0]       base_q;
  logic              busy_q, pfd_rstn_q, valid_q;
  logic [2:0]        rch_q;
  logic              sync_s1_q, sync_s2_q, pfd_s1_q, pfd_s2_q;
  logic [13:0]       res_q [NCH];

  logic              s1_sel, s2_sel;
  logic              gate_d;
  logic [DWELLW-1:0] dwell_last, settle_last;
  logic signed [14:0] diff;
  logic [13:0]       diff_sat;

  // Countdown reload values; dwell_i of 0 still yields a one-cycle window.
  assign dwell_last  = (dwell_i == '0) ? '0 : dwell_i - DWELLW'(1);
  assign settle_last = DWELLW'(settle_i) - DWELLW'(1);

  // NOTE: every signal written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    s1_sel = 1'b0;
    s2_sel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_q == 3'(i)) begin
        s1_sel = s1_i[i];
        s2_sel = s2_i[i];
      end
    end
  end

  // Delta of the integral over the dwell window, widened by one bit so the
  // subtraction cannot wrap, then clamped back to the 14-bit range.
  always_comb begin
    diff = $signed({pfd_integral_i[13], pfd_integral_i}) - $signed({base_q[13], base_q});
    case (diff[14:13])
      2'b01:   diff_sat = 14'h1FFF;   // above +8191
      2'b10:   diff_sat = 14'h2000;   // below -8192
      default: diff_sat = diff[13:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_en   = 1'b0;
    if (state_q != S_IDLE && !enable_i) begin
      // Disable wins over everything, including a pending capture.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i && (|ch_mask_i)) begin
            state_d = S_CLEAR;
            sel_d   = first_ch(ch_mask_i);
            cnt_d   = DWELLW'(1);
          end
        end
        S_CLEAR: begin
          if (cnt_q == '0) begin
            if (settle_i != 8'd0) begin
              state_d = S_SETTLE;
              cnt_d   = settle_last;
            end else begin
              state_d = S_DWELL;
              cnt_d   = dwell_last;
            end
          end else begin
            cnt_d = cnt_q - DWELLW'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = S_DWELL;
            cnt_d   = dwell_last;
          end else begin
            cnt_d = cnt_q - DWELLW'(1);
          end
        end
        S_DWELL: begin
          if (cnt_q == '0) state_d = S_CAPTURE;
          else             cnt_d   = cnt_q - DWELLW'(1);
        end
        S_CAPTURE: begin
          if (ch_mask_i == '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            wr_en   = 1'b1;
            sel_d   = next_ch(ch_mask_i, sel_q);
            state_d = S_CLEAR;
            cnt_d   = DWELLW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Signals reach the PFD only while it is out of reset and measuring.
  assign gate_d = (state_d == S_SETTLE) || (state_d == S_DWELL);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      first_q    <= 1'b0;
      base_q     <= '0;
      busy_q     <= 1'b0;
      pfd_rstn_q <= 1'b0;
      valid_q    <= 1'b0;
      rch_q      <= '0;
      sync_s1_q  <= 1'b0;
      sync_s2_q  <= 1'b0;
      pfd_s1_q   <= 1'b0;
      pfd_s2_q   <= 1'b0;
      // NOTE: the result store is a handful of registers, not a RAM, and is
      // cleared on reset so software never reads stale results.
      for (int i = 0; i < NCH; i++) res_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      busy_q     <= (state_d != S_IDLE);
      pfd_rstn_q <= (state_d == S_SETTLE) || (state_d == S_DWELL) || (state_d == S_CAPTURE);
      first_q    <= (state_d == S_DWELL) && (state_q != S_DWELL);
      // Two-flop synchronizer; the second stage doubles as the output gate.
      sync_s1_q  <= s1_sel;
      sync_s2_q  <= s2_sel;
      pfd_s1_q   <= gate_d & sync_s1_q;
      pfd_s2_q   <= gate_d & sync_s2_q;
      if (state_q == S_DWELL && first_q) base_q <= pfd_integral_i;
      valid_q <= wr_en;
      if (wr_en) rch_q <= sel_q;
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && sel_q == 3'(i)) res_q[i] <= diff_sat;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_res
    assign result_o[14*g +: 14] = res_q[g];
  end

  assign sel_o          = sel_q;
  assign busy_o         = busy_q;
  assign pfd_rstn_o     = pfd_rstn_q;
  assign pfd_s1_o       = pfd_s1_q;
  assign pfd_s2_o       = pfd_s2_q;
  assign result_valid_o = valid_q;
  assign result_ch_o    = rch_q;

endmodule
